tap_delay_line: RTL and testbench

//  Sample-side producer for the wavelet FIR bank: accepts a serial stream of

---
 rtl/tap_delay_line.sv | 119 +++++++++++
 tb/tb_tap_delay_line.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tap_delay_line.sv
// Sample delay line feeding the wavelet FIR bank.
// Accepts a serial sample stream and shifts it into a NUM_ELEM-deep window,
// which is presented in parallel on taps_o. Slot 0 always holds the newest
// sample. One window is emitted per DECIMATE accepted samples once the line
// has filled. The window stays frozen while it waits for the consumer.
//
// state | meaning
// FILL  | line not yet full; each accepted sample counts toward fill_level_o
// RUN   | line full; accepted samples count toward the next decimated window
// PEND  | window on taps_o is valid and waiting for taps_ready_i; input stalled
module tap_delay_line #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_ELEM      = 7,
    parameter int DECIMATE      = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [BITS_PER_ELEM-1:0]            sample_in_i,
    input  logic                                sample_valid_i,
    output logic                                sample_ready_o,
    input  logic                                flush_i,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0]   taps_o,
    output logic                                taps_valid_o,
    input  logic                                taps_ready_i,
    output logic [$clog2(NUM_ELEM+1)-1:0]       fill_level_o
);

    localparam int TAPS_W = NUM_ELEM * BITS_PER_ELEM;
    localparam int FILL_W = $clog2(NUM_ELEM + 1);
    localparam int DEC_W  = $clog2(DECIMATE) + 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_ELEM);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_ELEM - 1);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIMATE - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t              state_q;
    logic [TAPS_W-1:0]   taps_q;
    logic [TAPS_W-1:0]   taps_d;
    logic [FILL_W-1:0]   fill_q;
    logic [DEC_W-1:0]    dec_cnt_q;
    logic                taps_valid_q;
    logic                accept;

    // Input is stalled while a window waits, and during flush so nothing is
    // half-absorbed by a clearing line.
    assign sample_ready_o = (state_q != PEND) & ~flush_i;
    assign accept         = sample_valid_i & sample_ready_o;

    // Window after one shift: newest sample enters slot 0, oldest falls off.
    assign taps_d = {taps_q[TAPS_W-BITS_PER_ELEM-1:0], sample_in_i};

    assign taps_o       = taps_q;
    assign taps_valid_o = taps_valid_q;
    assign fill_level_o = fill_q;

    // Sequencer: window shift, fill/decimation counting and window handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= FILL;
            taps_q       <= '0;
            fill_q       <= '0;
            dec_cnt_q    <= '0;
            taps_valid_q <= 1'b0;
        end else if (flush_i) begin
            // Flush wins over a same-cycle taps_ready_i: the pending window is
            // discarded rather than handed over.
            state_q      <= FILL;
            taps_q       <= '0;
            fill_q       <= '0;
            dec_cnt_q    <= '0;
            taps_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        taps_q <= taps_d;
                        if (fill_q == FILL_LAST) begin
                            fill_q       <= FILL_FULL;
                            dec_cnt_q    <= '0;
                            taps_valid_q <= 1'b1;
                            state_q      <= PEND;
                        end else begin
                            fill_q <= fill_q + FILL_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        taps_q <= taps_d;
                        if (dec_cnt_q == DEC_LAST) begin
                            dec_cnt_q    <= '0;
                            taps_valid_q <= 1'b1;
                            state_q      <= PEND;
                        end else begin
                            dec_cnt_q <= dec_cnt_q + DEC_W'(1);
                        end
                    end
                end
                PEND: begin
                    if (taps_ready_i) begin
                        taps_valid_q <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                default: begin
                    taps_valid_q <= 1'b0;
                    state_q      <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: directed scenarios plus a randomized stream
// compared each cycle against a queue-based model of the sample window.
module tb_tap_delay_line;

    localparam int B = 8;
    localparam int N = 7;
    localparam int TW = N * B;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [B-1:0]  s_in;
    logic          s_vld;
    logic          s_rdy;
    logic          flush;
    logic [TW-1:0] taps;
    logic          tv;
    logic          t_rdy;
    logic [2:0]    fill;

    logic [B-1:0]  s3_in;
    logic          s3_vld;
    logic          s3_rdy;
    logic          flush3;
    logic [TW-1:0] taps3;
    logic          tv3;
    logic          t3_rdy;
    logic [2:0]    fill3;

    int checks = 0;
    int errors = 0;

    // reference model: accepted samples newest first, accept count, pending flag
    logic [B-1:0] m_q[$];
    int           m_n;
    bit           m_pend;

    always #5 clk = ~clk;

    tap_delay_line #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .DECIMATE(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .sample_in_i(s_in), .sample_valid_i(s_vld),
        .sample_ready_o(s_rdy), .flush_i(flush), .taps_o(taps), .taps_valid_o(tv),
        .taps_ready_i(t_rdy), .fill_level_o(fill)
    );

    tap_delay_line #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .DECIMATE(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .sample_in_i(s3_in), .sample_valid_i(s3_vld),
        .sample_ready_o(s3_rdy), .flush_i(flush3), .taps_o(taps3), .taps_valid_o(tv3),
        .taps_ready_i(t3_rdy), .fill_level_o(fill3)
    );

    function automatic logic [TW-1:0] m_taps();
        logic [TW-1:0] t = '0;
        for (int i = 0; i < m_q.size(); i++) t[i*B +: B] = m_q[i];
        return t;
    endfunction

    function automatic int m_fill();
        return (m_n > N) ? N : m_n;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_n = 0;
        m_pend = 1'b0;
    endtask

    // Window rule for DECIMATE=1: first window at the N-th accept, then every accept.
    task automatic model_step(input bit v, input logic [B-1:0] d, input bit tr, input bit fl);
        if (fl) begin
            model_clear();
        end else if (m_pend) begin
            if (tr) m_pend = 1'b0;
        end else if (v) begin
            m_q.push_front(d);
            if (m_q.size() > N) void'(m_q.pop_back());
            m_n++;
            if (m_n >= N) m_pend = 1'b1;
        end
    endtask

    // Apply inputs at a falling edge, advance the model across the rising edge,
    // return at the next falling edge with the inputs still applied.
    task automatic drive(input bit v, input logic [B-1:0] d, input bit tr, input bit fl);
        s_vld = v; s_in = d; t_rdy = tr; flush = fl;
        model_step(v, d, tr, fl);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_vld = 0; s_in = '0; flush = 0; t_rdy = 0;
        s3_vld = 0; s3_in = '0; flush3 = 0; t3_rdy = 0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++; if (taps !== '0) begin errors++; $display("FAIL reset_taps got %h exp 0", taps); end
        checks++; if (tv !== 1'b0) begin errors++; $display("FAIL reset_tv got %b exp 0", tv); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", s_rdy); end
    endtask

    task automatic test_fill_and_slide();
        for (int k = 1; k <= 7; k++) begin
            drive(1, B'(k), 1, 0);
            checks++; if (tv !== (k == 7)) begin errors++; $display("FAIL fill_tv k=%0d got %b exp %b", k, tv, k == 7); end
            checks++; if (fill !== 3'(k)) begin errors++; $display("FAIL fill_level k=%0d got %0d exp %0d", k, fill, k); end
        end
        checks++; if (taps !== 56'h01020304050607) begin errors++; $display("FAIL fill_taps got %h exp 01020304050607", taps); end
        drive(0, '0, 1, 0);
        checks++; if (tv !== 1'b0) begin errors++; $display("FAIL slide_tv_drop got %b exp 0", tv); end
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL slide_ready got %b exp 1", s_rdy); end
        drive(1, 8'd8, 1, 0);
        checks++; if (tv !== 1'b1) begin errors++; $display("FAIL slide_tv got %b exp 1", tv); end
        checks++; if (taps !== 56'h02030405060708) begin errors++; $display("FAIL slide_taps got %h exp 02030405060708", taps); end
        checks++; if (fill !== 3'd7) begin errors++; $display("FAIL slide_fill got %0d exp 7", fill); end
        drive(0, '0, 1, 0);
    endtask

    task automatic test_decimate();
        int k = 1;
        int cyc = 0;
        bit acc;
        while (k <= 13 && cyc < 60) begin
            s3_vld = 1; s3_in = B'(k); t3_rdy = 1;
            #1 acc = s3_rdy;
            @(negedge clk);
            cyc++;
            if (acc) begin
                checks++;
                if (tv3 !== (k >= N && (k - N) % 3 == 0)) begin
                    errors++; $display("FAIL decim_tv k=%0d got %b exp %b", k, tv3, (k >= N && (k - N) % 3 == 0));
                end
                if (k == 10) begin
                    checks++; if (taps3 !== 56'h0405060708090a) begin errors++; $display("FAIL decim_taps got %h exp 0405060708090a", taps3); end
                end
                k++;
            end
        end
        s3_vld = 0;
        checks++; if (k != 14) begin errors++; $display("FAIL decim_timeout accepted %0d exp 13", k - 1); end
        checks++; if (fill3 !== 3'd7) begin errors++; $display("FAIL decim_fill got %0d exp 7", fill3); end
    endtask

    task automatic test_backpressure();
        drive(0, '0, 0, 1);
        for (int k = 1; k <= 7; k++) drive(1, B'(k), 0, 0);
        checks++; if (tv !== 1'b1) begin errors++; $display("FAIL bp_tv got %b exp 1", tv); end
        for (int c = 0; c < 5; c++) begin
            drive(1, 8'd8, 0, 0);
            checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d got %b exp 0", c, s_rdy); end
            checks++; if (taps !== 56'h01020304050607) begin errors++; $display("FAIL bp_frozen c=%0d got %h exp 01020304050607", c, taps); end
        end
        drive(1, 8'd8, 1, 0);
        checks++; if (tv !== 1'b0) begin errors++; $display("FAIL bp_release_tv got %b exp 0", tv); end
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", s_rdy); end
        drive(1, 8'd8, 1, 0);
        checks++; if (taps !== 56'h02030405060708) begin errors++; $display("FAIL bp_next_taps got %h exp 02030405060708", taps); end
        checks++; if (tv !== 1'b1) begin errors++; $display("FAIL bp_next_tv got %b exp 1", tv); end
        drive(0, '0, 1, 0);
    endtask

    task automatic test_flush();
        drive(0, '0, 0, 1);
        for (int k = 1; k <= 7; k++) drive(1, B'(k), 0, 0);
        s_vld = 1; s_in = 8'h99; t_rdy = 1; flush = 1;
        #1;
        checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", s_rdy); end
        @(negedge clk);
        model_clear();
        checks++; if (tv !== 1'b0) begin errors++; $display("FAIL flush_tv got %b exp 0", tv); end
        checks++; if (taps !== '0) begin errors++; $display("FAIL flush_taps got %h exp 0", taps); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL flush_fill got %0d exp 0", fill); end
        for (int k = 1; k <= 7; k++) begin
            drive(1, B'(k + 16), 1, 0);
            checks++; if (tv !== (k == 7)) begin errors++; $display("FAIL flush_refill_tv k=%0d got %b exp %b", k, tv, k == 7); end
        end
        drive(0, '0, 1, 0);
    endtask

    task automatic test_reset_mid();
        drive(0, '0, 0, 1);
        for (int k = 1; k <= 4; k++) drive(1, B'(k), 1, 0);
        s_vld = 0;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++; if (taps !== '0) begin errors++; $display("FAIL rstmid_taps got %h exp 0", taps); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rstmid_fill got %0d exp 0", fill); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive(1, B'(k + 40), 1, 0);
            checks++; if (tv !== 1'b0) begin errors++; $display("FAIL rstmid_tv k=%0d got %b exp 0", k, tv); end
        end
        checks++; if (fill !== 3'd3) begin errors++; $display("FAIL rstmid_fill3 got %0d exp 3", fill); end
        drive(0, '0, 1, 0);
    endtask

    task automatic test_random();
        int bad = 0;
        drive(0, '0, 0, 1);
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0, B'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0);
            checks++;
            if (taps !== m_taps() || tv !== m_pend || fill !== 3'(m_fill()) ||
                s_rdy !== (!m_pend && !flush)) begin
                errors++;
                if (bad < 5) $display("FAIL rand c=%0d taps %h/%h tv %b/%b fill %0d/%0d rdy %b/%b",
                                      c, taps, m_taps(), tv, m_pend, fill, m_fill(), s_rdy, !m_pend && !flush);
                bad++;
            end
        end
        drive(0, '0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_fill_and_slide();
        test_decimate();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
